// File: rtl/control_fsm.sv
// Sequences the FIFO arbiter layer through RESET/INIT/IDLE/ACTIVE/ERROR and owns the FIFO thresholds.
// Latency: one edge from sampled input to state/flags; all outputs come from registers or state decode.
// Backpressure: arb_enable gates arbiter pop/push; it is low outside IDLE/ACTIVE and ERROR is absorbing.
module control_fsm #(
    parameter int THRESH_W    = 3,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [THRESH_W-1:0] umbral_af_in,
    input  logic [THRESH_W-1:0] umbral_ae_in,
    input  logic [3:0]          empty_in,
    input  logic [3:0]          empty_out,
    input  logic [7:0]          fifo_error,
    output logic [2:0]          estado,
    output logic [THRESH_W-1:0] umbral_af,
    output logic [THRESH_W-1:0] umbral_ae,
    output logic                arb_enable,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out,
    output logic [7:0]          error_src,
    output logic                cfg_error
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Counter value on the last all-empty edge before dropping back to IDLE.
    localparam logic [3:0] IDLE_TERM = 4'(IDLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idle_cnt;
    logic [3:0]  idle_cnt_nxt;
    logic        err_load;
    logic [7:0]  err_src_nxt;
    logic        cfg_err_nxt;
    logic        thr_load;
    logic        all_empty;
    logic        any_err;
    logic        cfg_ok;

    assign all_empty = (&empty_in) & (&empty_out);
    assign any_err   = |fifo_error;
    assign cfg_ok    = umbral_ae < umbral_af;

    // State register, idle counter and error capture.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_RESET;
            idle_cnt  <= 4'd0;
            error_src <= 8'd0;
            cfg_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            if (err_load) begin
                error_src <= err_src_nxt;
                cfg_error <= cfg_err_nxt;
            end
        end
    end

    // Thresholds track the inputs on every edge that enters or stays in INIT, and hold otherwise.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            umbral_af <= '0;
            umbral_ae <= '0;
        end else if (thr_load) begin
            umbral_af <= umbral_af_in;
            umbral_ae <= umbral_ae_in;
        end
    end

    // Next-state, counter and error-capture decisions; errors outrank init, which outranks traffic.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = 4'd0;
        err_load     = 1'b0;
        err_src_nxt  = fifo_error;
        cfg_err_nxt  = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt = ST_INIT;
            end
            ST_INIT: begin
                // fifo_error is ignored here: the FIFOs are mid-reconfiguration.
                if (!init) begin
                    if (cfg_ok) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_ERROR;
                        err_load    = 1'b1;
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (any_err) begin
                    state_nxt = ST_ERROR;
                    err_load  = 1'b1;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (!all_empty) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_err) begin
                    state_nxt = ST_ERROR;
                    err_load  = 1'b1;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (all_empty) begin
                    // Counter stops at the terminal value, so it can never wrap.
                    if (idle_cnt >= IDLE_TERM) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 4'd1;
                    end
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                // Corrupted state code: lock up without blaming config or a FIFO.
                state_nxt   = ST_ERROR;
                err_load    = 1'b1;
                err_src_nxt = 8'd0;
                cfg_err_nxt = 1'b0;
            end
        endcase
    end

    // Threshold load strobe, separate so the hold-outside-INIT rule is visible on its own.
    always_comb begin
        thr_load = (state == ST_INIT) || (state_nxt == ST_INIT);
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        estado     = state;
        idle_out   = (state == ST_IDLE);
        active_out = (state == ST_ACTIVE);
        error_out  = (state == ST_ERROR);
        arb_enable = (state == ST_IDLE) || (state == ST_ACTIVE);
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: a behavioural model checked every cycle plus literal spot checks.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
// Asynchronous reset is asserted between edges and checked immediately.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [2:0] umbral_af_in;
    logic [2:0] umbral_ae_in;
    logic [3:0] empty_in;
    logic [3:0] empty_out;
    logic [7:0] fifo_error;
    logic [2:0] estado;
    logic [2:0] umbral_af;
    logic [2:0] umbral_ae;
    logic       arb_enable;
    logic       idle_out;
    logic       active_out;
    logic       error_out;
    logic [7:0] error_src;
    logic       cfg_error;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int IDLE_N = 4;

    control_fsm #(.THRESH_W(3), .IDLE_CYCLES(IDLE_N)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_af_in (umbral_af_in),
        .umbral_ae_in (umbral_ae_in),
        .empty_in     (empty_in),
        .empty_out    (empty_out),
        .fifo_error   (fifo_error),
        .estado       (estado),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .arb_enable   (arb_enable),
        .idle_out     (idle_out),
        .active_out   (active_out),
        .error_out    (error_out),
        .error_src    (error_src),
        .cfg_error    (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: states by name-number, idle tracked as a run length of empty edges.
    int         m_state;
    int         m_run;
    logic [2:0] m_af;
    logic [2:0] m_ae;
    logic [7:0] m_src;
    logic       m_cfg;

    always @(posedge clk or negedge reset_L) begin
        int nxt;
        bit all_e;
        bit any_e;
        if (!reset_L) begin
            m_state = 0;
            m_run   = 0;
            m_af    = 3'd0;
            m_ae    = 3'd0;
            m_src   = 8'd0;
            m_cfg   = 1'b0;
        end else begin
            all_e = (empty_in == 4'hF) && (empty_out == 4'hF);
            any_e = (fifo_error != 8'd0);
            nxt   = m_state;
            if (m_state == 0) begin
                nxt = 1;
            end else if (m_state == 1) begin
                if (!init) begin
                    if (m_ae < m_af) nxt = 2;
                    else begin nxt = 4; m_cfg = 1'b1; m_src = fifo_error; end
                end
            end else if (m_state == 2 || m_state == 3) begin
                if (any_e) begin
                    nxt = 4; m_cfg = 1'b0; m_src = fifo_error;
                end else if (init) begin
                    nxt = 1;
                end else if (m_state == 2) begin
                    if (!all_e) begin nxt = 3; m_run = 0; end
                end else if (all_e) begin
                    m_run = m_run + 1;
                    if (m_run == IDLE_N) nxt = 2;
                end else begin
                    m_run = 0;
                end
            end
            if (m_state == 1 || nxt == 1) begin
                m_af = umbral_af_in;
                m_ae = umbral_ae_in;
            end
            m_state = nxt;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_estado", 32'(estado), 32'(m_state));
        chk("m_af", 32'(umbral_af), 32'(m_af));
        chk("m_ae", 32'(umbral_ae), 32'(m_ae));
        chk("m_arb", 32'(arb_enable), 32'(m_state == 2 || m_state == 3));
        chk("m_idle", 32'(idle_out), 32'(m_state == 2));
        chk("m_active", 32'(active_out), 32'(m_state == 3));
        chk("m_error", 32'(error_out), 32'(m_state == 4));
        chk("m_src", 32'(error_src), 32'(m_src));
        chk("m_cfg", 32'(cfg_error), 32'(m_cfg));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_L      = 1'b0;
        init         = 1'b0;
        umbral_af_in = 3'd6;
        umbral_ae_in = 3'd2;
        empty_in     = 4'hF;
        empty_out    = 4'hF;
        fifo_error   = 8'h00;
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_arb", 32'(arb_enable), 32'd0);
        chk("rst_af", 32'(umbral_af), 32'd0);

        // Reset release: RESET -> INIT -> IDLE over two edges.
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        chk("seq_init", 32'(estado), 32'd1);
        @(negedge clk);
        chk("seq_idle", 32'(estado), 32'd2);
        chk("seq_af", 32'(umbral_af), 32'd6);
        chk("seq_ae", 32'(umbral_ae), 32'd2);
        chk("seq_arb", 32'(arb_enable), 32'd1);

        // Held init reloads thresholds every edge; last value wins.
        init = 1'b1;
        umbral_af_in = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_init", 32'(estado), 32'd1);
            if (i == 2) umbral_af_in = 3'd7;
        end
        init = 1'b0;
        @(negedge clk);
        chk("hold_idle", 32'(estado), 32'd2);
        chk("hold_af", 32'(umbral_af), 32'd7);

        // Non-empty pulse enters ACTIVE; IDLE returns after four empty edges.
        empty_in = 4'b1011;
        @(negedge clk);
        chk("act_enter", 32'(estado), 32'd3);
        empty_in = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("act_count", 32'(estado), (i < 4) ? 32'd3 : 32'd2);
        end

        // Non-empty pulse after three empty edges restarts the count.
        empty_in = 4'b1011;
        @(negedge clk);
        empty_in = 4'hF;
        repeat (3) @(negedge clk);
        empty_in = 4'b1011;
        @(negedge clk);
        chk("restart_pulse", 32'(estado), 32'd3);
        empty_in = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("restart_count", 32'(estado), (i < 4) ? 32'd3 : 32'd2);
        end

        // init on the terminal idle-count edge wins: INIT.
        empty_in = 4'b1011;
        @(negedge clk);
        empty_in = 4'hF;
        repeat (3) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        chk("term_init", 32'(estado), 32'd1);
        init = 1'b0;
        @(negedge clk);
        chk("term_idle", 32'(estado), 32'd2);

        // Bad thresholds (ae >= af) lock into ERROR with cfg_error.
        init = 1'b1;
        umbral_af_in = 3'd3;
        umbral_ae_in = 3'd7;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        chk("cfg_estado", 32'(estado), 32'd4);
        chk("cfg_flag", 32'(cfg_error), 32'd1);
        chk("cfg_arb", 32'(arb_enable), 32'd0);

        reset_L = 1'b0;
        umbral_af_in = 3'd6;
        umbral_ae_in = 3'd2;
        #1;
        chk("cfg_rst", 32'(cfg_error), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        chk("rerun_idle", 32'(estado), 32'd2);

        // FIFO error together with init in ACTIVE: ERROR wins, snapshot captured.
        empty_out = 4'b1101;
        @(negedge clk);
        chk("err_active", 32'(estado), 32'd3);
        fifo_error = 8'h20;
        init = 1'b1;
        @(negedge clk);
        chk("err_estado", 32'(estado), 32'd4);
        chk("err_src", 32'(error_src), 32'h20);
        chk("err_cfg", 32'(cfg_error), 32'd0);
        fifo_error = 8'h00;
        for (int i = 0; i < 4; i++) begin
            init = ~init;
            @(negedge clk);
            chk("err_absorb", 32'(estado), 32'd4);
        end
        init = 1'b0;
        empty_out = 4'hF;

        // Asynchronous reset between edges while ACTIVE.
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        empty_in = 4'b1110;
        @(negedge clk);
        chk("ar_active", 32'(estado), 32'd3);
        @(posedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        chk("ar_estado", 32'(estado), 32'd0);
        chk("ar_flags", 32'({arb_enable, idle_out, active_out, error_out, cfg_error}), 32'd0);
        chk("ar_thr", 32'({umbral_af, umbral_ae}), 32'd0);
        chk("ar_src", 32'(error_src), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        empty_in = 4'hF;
        @(negedge clk);
        chk("ar_init", 32'(estado), 32'd1);
        @(negedge clk);
        chk("ar_idle", 32'(estado), 32'd2);
        chk("ar_af", 32'(umbral_af), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Transaction-layer control state machine for the 4-in/4-out FIFO arbiter datapath. It sequences the layer through reset, configuration, idle, active and error states. It latches and validates the almost-full/almost-empty thresholds driven to all eight FIFOs, and gates the arbiter's pop/push through `arb_enable`. It flags idle after sustained emptiness and locks into error on any FIFO overflow/underflow.

## Interface
- `THRESH_W`, 3: width of each threshold value.
- `IDLE_CYCLES`, 4: consecutive all-empty cycles in ACTIVE required to return to IDLE; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  configuration request; level-sensitive.
- `umbral_af_in`  in  THRESH_W  requested almost-full threshold.
- `umbral_ae_in`  in  THRESH_W  requested almost-empty threshold.
- `empty_in`  in  4  empty flags of the four input FIFOs, bit i = port i.
- `empty_out`  in  4  empty flags of the four output FIFOs.
- `fifo_error`  in  8  overflow/underflow flags; [3:0] input FIFOs, [7:4] output FIFOs.
- `estado`  out  3  current state code.
- `umbral_af`  out  THRESH_W  registered almost-full threshold to all FIFOs.
- `umbral_ae`  out  THRESH_W  registered almost-empty threshold to all FIFOs.
- `arb_enable`  out  1  arbiter may pop/push.
- `idle_out`  out  1  high in IDLE.
- `active_out`  out  1  high in ACTIVE.
- `error_out`  out  1  high in ERROR.
- `error_src`  out  8  `fifo_error` snapshot captured on entry to ERROR.
- `cfg_error`  out  1  ERROR was entered because of invalid thresholds.

## Operation
- State codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5-7 are unreachable; if ever decoded, go to ERROR with `cfg_error=0` and `error_src=0`.
- Moore machine. All outputs are registered or decoded from the state register only.
- "all_empty" = `&empty_in & &empty_out`. "any_err" = `|fifo_error`. "cfg_ok" = `umbral_ae < umbral_af`, evaluated on the registered values.
- RESET: go to INIT on the first rising edge after `reset_L` deasserts. No other condition applies.
- INIT:
  - `umbral_af`/`umbral_ae` load from the `_in` ports on every edge while in INIT.
  - While `init`=1, stay in INIT.
  - When `init`=0 and cfg_ok, go to IDLE.
  - When `init`=0 and not cfg_ok, go to ERROR with `cfg_error`=1.
  - `fifo_error` is ignored in INIT, because FIFOs are being reconfigured.
- IDLE, priority high to low:
  - any_err: go to ERROR.
  - `init`=1: go to INIT.
  - !all_empty: go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE, priority high to low:
  - any_err: go to ERROR.
  - `init`=1: go to INIT.
  - all_empty sampled for IDLE_CYCLES consecutive edges: go to IDLE.
  - Otherwise stay in ACTIVE.
- ERROR: absorbing. `init` and all other inputs are ignored. Only `reset_L` low exits.
- Idle counter (4 bits):
  - Clears on entry to ACTIVE and on any cycle with !all_empty.
  - Increments in ACTIVE on each all_empty cycle.
  - When it reaches IDLE_CYCLES-1 with all_empty also true, the next state is IDLE.
  - It never wraps.
- Thresholds hold their value outside INIT. Re-entering INIT from IDLE/ACTIVE reloads them.
- `arb_enable`=1 only in IDLE and ACTIVE.
- `error_src`/`cfg_error` load only on the transition into ERROR and then hold until reset.

## Timing
- Asserting `reset_L`=0 immediately forces, with no clock needed: state RESET, `estado`=0, thresholds=0, counter=0, `error_src`=0, and `cfg_error`, `arb_enable`, `idle_out`, `active_out`, `error_out` all 0.
- Input-to-state latency is one edge. A condition sampled at edge N is reflected in `estado` and the flags after edge N.
- Minimum path from reset release: INIT after edge 1. With `init` already 0 and cfg_ok, IDLE after edge 2. Thresholds loaded at edge 1 are valid for the cfg_ok check at edge 2.
- `arb_enable` drops in the same cycle that `estado` becomes ERROR or INIT. The arbiter therefore sees at most one enabled cycle after a FIFO error is raised.
- Simultaneous events:
  - any_err together with `init`: go to ERROR.
  - `init` together with the idle-count terminal: go to INIT, counter cleared.
  - FIFO becomes non-empty on the terminal cycle: stay in ACTIVE, counter cleared.
- Reset mid-operation in any state returns to RESET asynchronously. Captured error info is lost.

## Test plan
- Reset release with `init`=0, `umbral_af_in`=6, `umbral_ae_in`=2: `estado` 0→1→2 across two edges; `umbral_af`=6, `umbral_ae`=2; `arb_enable`=1 from the IDLE cycle.
- Hold `init`=1 for 5 cycles while changing `umbral_af_in` 5→7, then drop `init`: stays INIT, final `umbral_af`=7, then IDLE. With `umbral_ae_in`=7, `umbral_af_in`=3 instead: goes to ERROR, `cfg_error`=1, `arb_enable`=0.
- In IDLE, clear `empty_in[2]` for 1 cycle, then all empty: ACTIVE next edge; IDLE exactly 4 edges after emptiness with IDLE_CYCLES=4. A non-empty pulse at all-empty count 3 restarts the count.
- In ACTIVE, pulse `fifo_error`=8'h20 for 1 cycle together with `init`=1: ERROR, `error_src`=8'h20, `cfg_error`=0. Subsequent `init` pulses do not leave ERROR.
- Assert `reset_L`=0 between clock edges while in ACTIVE: all outputs are 0 immediately. After release the RESET→INIT→IDLE sequence repeats.
